lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit directly downstream of the ALU in the single-cycle RISC-V core. Takes the ALU result as effective address, issues one request on a valid/grant memory bus, and formats load data for the register file. Stalls the core (PC and regfile write) until the access finishes, then gives a one-cycle completion pulse. Misaligned, illegal or timed-out accesses are reported as error pulses.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+RSP before bus error (8-bit counter, 1..255)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  load instruction present (decoder)
mem_write  in  1  store instruction present (decoder)
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  effective address (ALU result)
store_data  in  32  rs2 value
stall  out  1  hold PC/regfile this cycle
load_data  out  32  extended load result
load_valid  out  1  one-cycle pulse: load_data valid, regfile write
misalign  out  1  one-cycle pulse: misaligned access
bus_err  out  1  one-cycle pulse: timeout or illegal funct3
bus_req  out  1  request valid
bus_we  out  1  1=write
bus_addr  out  32  word address, [1:0]=00
bus_wdata  out  32  lane-replicated write data
bus_be  out  4  byte enables
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read word

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; load_data 0; timeout counter 0. bus_req falls immediately, no handshake completion.
- States IDLE, REQ, RSP, DONE.
- IDLE: req = mem_read|mem_write; both set -> treated as write. When req: capture addr, funct3, we, bus_addr, bus_be, bus_wdata into registers; stall=1 (combinational, same cycle). Aligned and legal -> REQ. Misaligned (H: addr[0]=1; W: addr[1:0]!=0) -> DONE with misalign flag. Illegal funct3 (011, 110, 111; stores also 100, 101) -> DONE with error flag. No bus access in either error case.
- REQ: bus_req=1, bus_we/addr/be/wdata from registers, stable until gnt. stall=1. gnt & write -> DONE (posted write). gnt & read -> RSP.
- RSP: bus_req=0, stall=1. bus_rvalid sampled only here (earliest one cycle after gnt). rvalid -> latch formatted load_data -> DONE with load flag.
- DONE: stall=0; exactly one of load_valid (read), misalign, bus_err pulses, or none (successful store). Unconditional -> IDLE. Guarantees no relaunch of an instruction still on the inputs.
- Timeout: counter clears on IDLE exit, increments each cycle in REQ/RSP; reaching TIMEOUT -> DONE with bus_err, bus_req dropped; late gnt/rvalid ignored.
- Byte enables: B -> 0001<<addr[1:0], wdata = byte x4; H -> 0011 (addr[1]=0) / 1100, wdata = half x2; W -> 1111, wdata = store_data.
- Load format: shift rdata right by 8*addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged. load_data holds last value otherwise.
- Latency (gnt immediate, rvalid next cycle): load 4 cycles (IDLE,REQ,RSP,DONE), store 3.

Decomposition:
- Package lsu_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, TIMEOUT default.
- Sub-module lsu_align (combinational): byte-enable/write-lane generation, misalign/illegal detect, load extraction/extension; lsu_ctrl holds FSM, registers, counter.

Test Plan:
- LW addr 0x100, gnt in REQ, rvalid next cycle rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, load_valid in cycle 4, load_data 0xDEADBEEF, stall high cycles 1-3.
- LB addr 0x103, rdata 0x80000000 -> be 1000, load_data 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202 data 0x1234ABCD, gnt delayed 3 cycles -> bus_req held 4 cycles, addr 0x200, be 1100, wdata 0xABCDABCD, DONE without load_valid.
- LW addr 0x101 -> no bus_req, misalign pulse one cycle after request; SB funct3 110 -> bus_err pulse, no access.
- TIMEOUT=4, gnt never -> bus_req drops after 4 cycles, bus_err pulse, next instruction accepted.
- rst asserted in RSP -> bus_req/stall/outputs 0 immediately, state IDLE; later rvalid ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states
// and the default bus timeout.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated write data for the
// request side, alignment/legality checks, and load-word extraction with
// sign or zero extension for the response side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic        o_illegal,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shift;

  // Request side: lanes, replicated data, misalignment and illegal sizes.
  // Unsigned sizes only make sense for loads, so they are illegal on stores.
  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be      = 4'b0001 << i_off;
        o_wdata   = {4{i_wdata[7:0]}};
        o_illegal = i_we && (i_funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        o_be       = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_off[0];
        o_illegal  = i_we && (i_funct3 == F3_HU);
      end
      F3_W: begin
        o_be       = 4'b1111;
        o_misalign = (i_off != 2'b00);
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign w_shift = i_rdata >> {i_ld_off, 3'b000};

  // Response side: bring the addressed byte/half down to bit 0 and extend.
  always_comb begin
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_BU:   o_ld_data = {24'd0, w_shift[7:0]};
      F3_H:    o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_HU:   o_ld_data = {16'd0, w_shift[15:0]};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: captures one access from the decoder/ALU,
// runs it on the valid/grant bus, stalls the core until it finishes and
// emits a single-cycle completion, misalign or bus-error pulse.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_e  r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_we;
  logic        r_bus_req;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_misalign;
  logic        r_bus_err;

  logic        w_req;
  logic        w_we;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic        w_illegal;
  logic [31:0] w_ld_data;

  // A write wins when the decoder asserts both strobes.
  assign w_req     = mem_read | mem_write;
  assign w_we      = mem_write;
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  lsu_align u_align (
    .i_funct3    (funct3),
    .i_off       (addr[1:0]),
    .i_we        (w_we),
    .i_wdata     (store_data),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_misalign  (w_misalign),
    .o_illegal   (w_illegal),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_rdata     (bus_rdata),
    .o_ld_data   (w_ld_data)
  );

  // Stall is combinational so the core freezes in the cycle the access shows up.
  assign stall = !rst && ((r_state == S_IDLE && w_req) ||
                          r_state == S_REQ || r_state == S_RSP);

  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;
  assign misalign   = r_misalign;
  assign bus_err    = r_bus_err;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_be     = r_bus_be;

  // Access FSM with timeout counter; all status outputs are registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_we         <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_addr   <= 32'd0;
      r_bus_wdata  <= 32'd0;
      r_bus_be     <= 4'd0;
      r_load_data  <= 32'd0;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we        <= w_we;
            r_funct3    <= funct3;
            r_off       <= addr[1:0];
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_cnt       <= 8'd0;
            if (w_illegal) begin
              r_bus_err <= 1'b1;
              r_state   <= S_DONE;
            end else if (w_misalign) begin
              r_misalign <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_bus_req <= 1'b1;
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= r_we ? S_DONE : S_RSP;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_RSP: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus_rvalid) begin
            r_load_data  <= w_ld_data;
            r_load_valid <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a bus responder with programmable grant delay, a
// driver that issues one instruction at a time and checks the bus request,
// and a completion monitor fed by an expected-result queue.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  typedef struct {
    logic [2:0]  flags;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          gnt_delay = 0;
  logic        hold_rv  = 1'b0;
  logic        stray_rv = 1'b0;
  logic [31:0] mem_word = 32'd0;
  logic [31:0] last_ld  = 32'd0;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Bus responder: grant after gnt_delay request cycles, read data the cycle after.
  initial begin
    int   req_seen;
    logic rv_pend;
    req_seen   = 0;
    rv_pend    = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      if (rv_pend || stray_rv) begin
        bus_rvalid = 1'b1;
        bus_rdata  = mem_word;
        rv_pend    = 1'b0;
      end
      if (bus_req) begin
        if (req_seen == gnt_delay) begin
          bus_gnt = 1'b1;
          rv_pend = !bus_we && !hold_rv;
        end
        req_seen++;
      end else begin
        req_seen = 0;
      end
    end
  end

  // Completion monitor: the cycle stall falls after being high is DONE.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (prev && !stall) begin
          if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check_val("done_flags", {29'd0, load_valid, misalign, bus_err}, {29'd0, e.flags});
            check_val("done_ldata", load_data, e.data);
          end
        end
        prev = stall;
      end
    end
  end

  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int gd,
                        input logic [31:0] rdata, input logic [2:0] flags, input logic [31:0] res,
                        input int exp_waits, input int exp_reqc, input logic [31:0] exp_baddr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_we);
    int   waits;
    int   reqc;
    logic done;
    exp_t e;
    if (flags == 3'b100) last_ld = res;
    e.flags = flags;
    e.data  = last_ld;
    sb.push_back(e);
    gnt_delay  = gd;
    mem_word   = rdata;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    #1;
    check_val({tag, "_stall0"}, {31'd0, stall}, 32'd1);
    waits = 0;
    reqc  = 0;
    done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      waits++;
      if (bus_req) begin
        reqc++;
        check_val({tag, "_baddr"}, bus_addr, exp_baddr);
        check_val({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
        check_val({tag, "_wdata"}, bus_wdata, exp_wd);
        check_val({tag, "_we"}, {31'd0, bus_we}, {31'd0, exp_we});
      end
      if (!stall) done = 1'b1;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
    check_val({tag, "_cycles"}, waits, exp_waits);
    check_val({tag, "_reqcyc"}, reqc, exp_reqc);
    @(negedge clk);
    check_val({tag, "_pulse_end"}, {28'd0, load_valid, misalign, bus_err, stall}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'd0;
    addr       = 32'd0;
    store_data = 32'd0;
    repeat (2) @(negedge clk);
    check_val("rst_outs", {26'd0, stall, load_valid, misalign, bus_err, bus_req, bus_we}, 32'd0);
    check_val("rst_ldata", load_data, 32'd0);
    check_val("rst_baddr", bus_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("lw",     1, 0, 3'b010, 32'h100, 32'h0,        0, 32'hDEADBEEF, 3'b100, 32'hDEADBEEF, 3, 1, 32'h100, 4'hF, 32'h0,        1'b0);
    run_op("lb",     1, 0, 3'b000, 32'h103, 32'h11,       0, 32'h80000000, 3'b100, 32'hFFFFFF80, 3, 1, 32'h100, 4'h8, 32'h11111111, 1'b0);
    run_op("lbu",    1, 0, 3'b100, 32'h103, 32'h11,       0, 32'h80000000, 3'b100, 32'h00000080, 3, 1, 32'h100, 4'h8, 32'h11111111, 1'b0);
    run_op("lh",     1, 0, 3'b001, 32'h102, 32'h0,        0, 32'h80010000, 3'b100, 32'hFFFF8001, 3, 1, 32'h100, 4'hC, 32'h0,        1'b0);
    run_op("lhu",    1, 0, 3'b101, 32'h102, 32'h0,        0, 32'h80010000, 3'b100, 32'h00008001, 3, 1, 32'h100, 4'hC, 32'h0,        1'b0);
    run_op("sh",     0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'h0,        3'b000, 32'h0,        5, 4, 32'h200, 4'hC, 32'hABCDABCD, 1'b1);
    run_op("sb",     0, 1, 3'b000, 32'h201, 32'h000000A5, 1, 32'h0,        3'b000, 32'h0,        3, 2, 32'h200, 4'h2, 32'hA5A5A5A5, 1'b1);
    run_op("sw",     0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0,        3'b000, 32'h0,        2, 1, 32'h300, 4'hF, 32'hCAFEF00D, 1'b1);
    run_op("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0,        0, 32'h0,        3'b010, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        1'b0);
    run_op("lh_mis", 1, 0, 3'b001, 32'h103, 32'h0,        0, 32'h0,        3'b010, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        1'b0);
    run_op("s_f110", 0, 1, 3'b110, 32'h200, 32'h0,        0, 32'h0,        3'b001, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        1'b0);
    run_op("s_bu",   0, 1, 3'b100, 32'h200, 32'h0,        0, 32'h0,        3'b001, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        1'b0);
    run_op("l_f011", 1, 0, 3'b011, 32'h200, 32'h0,        0, 32'h0,        3'b001, 32'h0,        1, 0, 32'h0,   4'h0, 32'h0,        1'b0);
    run_op("rw_sw",  1, 1, 3'b010, 32'h308, 32'h600DCAFE, 0, 32'h0,        3'b000, 32'h0,        2, 1, 32'h308, 4'hF, 32'h600DCAFE, 1'b1);
    run_op("tmo",    1, 0, 3'b010, 32'h400, 32'h0,       99, 32'h0,        3'b001, 32'h0,        5, 4, 32'h400, 4'hF, 32'h0,        1'b0);
    run_op("lw_aft", 1, 0, 3'b010, 32'h404, 32'h0,        0, 32'h11223344, 3'b100, 32'h11223344, 3, 1, 32'h404, 4'hF, 32'h0,        1'b0);
    run_op("lb_pos", 1, 0, 3'b000, 32'h000, 32'h0,        0, 32'h1234567F, 3'b100, 32'h0000007F, 3, 1, 32'h000, 4'h1, 32'h0,        1'b0);

    // Reset while waiting for read data.
    hold_rv   = 1'b1;
    gnt_delay = 0;
    mem_word  = 32'h55AA55AA;
    mem_read  = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h100;
    @(negedge clk);
    check_val("rst_req_up", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    check_val("rst_rsp_stall", {30'd0, stall, bus_req}, 32'd2);
    #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    #1;
    check_val("rst_imm_outs", {26'd0, stall, load_valid, misalign, bus_err, bus_req, bus_we}, 32'd0);
    check_val("rst_imm_ldata", load_data, 32'd0);
    check_val("rst_imm_be", {28'd0, bus_be}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    hold_rv = 1'b0;
    #1;
    stray_rv = 1'b1;
    @(negedge clk);
    #1;
    stray_rv = 1'b0;
    @(negedge clk);
    check_val("late_rv_ign", {29'd0, load_valid, stall, bus_req}, 32'd0);
    check_val("late_rv_ldata", load_data, 32'd0);
    last_ld = 32'd0;

    run_op("lw_rst", 1, 0, 3'b010, 32'h010, 32'h0, 0, 32'h0BADF00D, 3'b100, 32'h0BADF00D, 3, 1, 32'h010, 4'hF, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    check_val("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
